// File: rtl/bt_cmd_ctrl.sv
// Bluetooth command sequencer: frames UART bytes into AA/CMD/ARG/CHK packets,
// validates them and drives song selection, play state and start/stop strobes.
module bt_cmd_ctrl #(
   parameter int NUM_SONGS   = 10,
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic [3:0] choose,
   output logic       playing,
   output logic       start_pulse,
   output logic       stop_pulse,
   output logic       busy,
   output logic [7:0] err_cnt
);

   localparam int GAP_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CYC - 1);
   localparam logic [7:0]       SONGS_B   = 8'(NUM_SONGS);
   localparam logic [3:0]       LAST_SONG = 4'(NUM_SONGS - 1);

   localparam logic [7:0] SYNC_BYTE  = 8'hAA;
   localparam logic [7:0] CMD_SELECT = 8'h01;
   localparam logic [7:0] CMD_PLAY   = 8'h02;
   localparam logic [7:0] CMD_STOP   = 8'h03;
   localparam logic [7:0] CMD_NEXT   = 8'h04;

   typedef enum logic [2:0] {
      IDLE,
      GET_CMD,
      GET_ARG,
      GET_CHK,
      EXEC
   } state_t;

   state_t           state_q;
   logic [7:0]       cmd_q, arg_q, chk_q;
   logic [GAP_W-1:0] gap_q;
   logic [3:0]       choose_q, choose_d;
   logic             playing_q, playing_d;
   logic             start_q, start_d;
   logic             stop_q, stop_d;
   logic [7:0]       err_q, err_d;
   logic             reject;

   // Outcome of executing the latched packet; only consumed in EXEC.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      choose_d  = choose_q;
      playing_d = playing_q;
      start_d   = 1'b0;
      stop_d    = 1'b0;
      reject    = 1'b0;
      if (chk_q != (cmd_q ^ arg_q)) begin
         reject = 1'b1;
      end else begin
         case (cmd_q)
            CMD_SELECT: begin
               if (arg_q < SONGS_B) begin
                  choose_d = arg_q[3:0];
                  if (playing_q) begin
                     playing_d = 1'b0;
                     stop_d    = 1'b1;
                  end
               end else begin
                  reject = 1'b1;
               end
            end
            CMD_PLAY: begin
               playing_d = 1'b1;
               start_d   = 1'b1;
            end
            CMD_STOP: begin
               if (playing_q) begin
                  playing_d = 1'b0;
                  stop_d    = 1'b1;
               end
            end
            CMD_NEXT: choose_d = (choose_q == LAST_SONG) ? 4'd0 : choose_q + 4'd1;
            default:  reject = 1'b1;
         endcase
      end
      err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         cmd_q     <= 8'h00;
         arg_q     <= 8'h00;
         chk_q     <= 8'h00;
         gap_q     <= '0;
         choose_q  <= 4'd0;
         playing_q <= 1'b0;
         start_q   <= 1'b0;
         stop_q    <= 1'b0;
         err_q     <= 8'h00;
      end else begin
         start_q <= 1'b0;
         stop_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rx_valid && rx_data == SYNC_BYTE) state_q <= GET_CMD;
            end
            GET_CMD: begin
               if (rx_valid) begin
                  cmd_q   <= rx_data;
                  state_q <= GET_ARG;
               end
            end
            GET_ARG: begin
               if (rx_valid) begin
                  arg_q   <= rx_data;
                  state_q <= GET_CHK;
               end
            end
            GET_CHK: begin
               if (rx_valid) begin
                  chk_q   <= rx_data;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               if (reject) begin
                  err_q <= err_d;
               end else begin
                  choose_q  <= choose_d;
                  playing_q <= playing_d;
                  start_q   <= start_d;
                  stop_q    <= stop_d;
               end
               state_q <= (rx_valid && rx_data == SYNC_BYTE) ? GET_CMD : IDLE;
            end
            default: state_q <= IDLE;
         endcase

         // Inter-byte gap watchdog; an arriving byte always beats expiry.
         if (state_q inside {GET_CMD, GET_ARG, GET_CHK}) begin
            if (rx_valid) begin
               gap_q <= '0;
            end else if (gap_q == GAP_LAST) begin
               gap_q   <= '0;
               state_q <= IDLE;
               err_q   <= err_d;
            end else begin
               gap_q <= gap_q + 1'b1;
            end
         end else begin
            gap_q <= '0;
         end
      end
   end

   assign choose      = choose_q;
   assign playing     = playing_q;
   assign start_pulse = start_q;
   assign stop_pulse  = stop_q;
   assign busy        = (state_q != IDLE);
   assign err_cnt     = err_q;

endmodule

// File: tb/tb_bt_cmd_ctrl.sv
// Directed bench for bt_cmd_ctrl: inputs change and outputs are sampled 1 ns
// after the rising edge, so each sample reflects the state just registered.
module tb_bt_cmd_ctrl;

   localparam int NUM_SONGS   = 10;
   localparam int TIMEOUT_CYC = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [3:0] choose;
   logic       playing, start_pulse, stop_pulse, busy;
   logic [7:0] err_cnt;

   int n_checks = 0;
   int n_errors = 0;

   bt_cmd_ctrl #(
      .NUM_SONGS  (NUM_SONGS),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .choose     (choose),
      .playing    (playing),
      .start_pulse(start_pulse),
      .stop_pulse (stop_pulse),
      .busy       (busy),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents one byte for exactly one cycle; returns 1 ns after the sampling edge.
   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   // Full packet; returns in the cycle where results and pulses are visible (t+2).
   task automatic send_pkt(input logic [7:0] cmd, input logic [7:0] arg, input logic [7:0] chk);
      send_byte(8'hAA);
      send_byte(cmd);
      send_byte(arg);
      send_byte(chk);
      tick(1);
   endtask

   initial begin
      tick(3);
      rst = 1'b1;
      check("rst_choose", choose, 4'd0);
      check("rst_playing", playing, 1'b0);
      check("rst_start", start_pulse, 1'b0);
      check("rst_stop", stop_pulse, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_err", err_cnt, 8'd0);

      send_byte(8'h55);
      check("junk_busy", busy, 1'b0);
      check("junk_err", err_cnt, 8'd0);

      // SELECT 3 with explicit latency checks
      send_byte(8'hAA);
      check("busy_after_sync", busy, 1'b1);
      send_byte(8'h01);
      send_byte(8'h03);
      send_byte(8'h02);
      check("exec_busy", busy, 1'b1);
      check("exec_choose_old", choose, 4'd0);
      tick(1);
      check("sel3_choose", choose, 4'd3);
      check("sel3_playing", playing, 1'b0);
      check("sel3_start", start_pulse, 1'b0);
      check("sel3_stop", stop_pulse, 1'b0);
      check("sel3_err", err_cnt, 8'd0);
      check("sel3_busy", busy, 1'b0);

      send_pkt(8'h02, 8'h00, 8'h02);
      check("play_start", start_pulse, 1'b1);
      check("play_stop", stop_pulse, 1'b0);
      check("play_playing", playing, 1'b1);
      tick(1);
      check("play_start_low", start_pulse, 1'b0);

      send_pkt(8'h01, 8'h05, 8'h04);
      check("sel5_choose", choose, 4'd5);
      check("sel5_stop", stop_pulse, 1'b1);
      check("sel5_start", start_pulse, 1'b0);
      check("sel5_playing", playing, 1'b0);
      tick(1);
      check("sel5_stop_low", stop_pulse, 1'b0);

      send_pkt(8'h03, 8'h00, 8'h03);
      check("stop_idle_pulse", stop_pulse, 1'b0);
      check("stop_idle_err", err_cnt, 8'd0);

      send_pkt(8'h01, 8'h0A, 8'h0B);
      check("range_choose", choose, 4'd5);
      check("range_err", err_cnt, 8'd1);

      send_pkt(8'h05, 8'h11, 8'h14);
      check("badcmd_err", err_cnt, 8'd2);

      send_pkt(8'h03, 8'h00, 8'hFF);
      check("badchk_err", err_cnt, 8'd3);

      send_pkt(8'h01, 8'h09, 8'h08);
      check("sel9_choose", choose, 4'd9);
      send_pkt(8'h04, 8'h00, 8'h04);
      check("next_wrap", choose, 4'd0);
      send_pkt(8'h04, 8'h00, 8'h04);
      check("next_1", choose, 4'd1);
      check("next_start", start_pulse, 1'b0);
      check("next_stop", stop_pulse, 1'b0);

      send_pkt(8'h02, 8'h00, 8'h02);
      check("play2_start", start_pulse, 1'b1);
      send_pkt(8'h04, 8'h00, 8'h04);
      check("next_play_choose", choose, 4'd2);
      check("next_play_playing", playing, 1'b1);
      check("next_play_pulse", {start_pulse, stop_pulse}, 2'b00);
      send_pkt(8'h02, 8'h00, 8'h02);
      check("restart_start", start_pulse, 1'b1);
      check("restart_playing", playing, 1'b1);

      // STOP followed by a sync byte during the EXEC cycle
      send_byte(8'hAA);
      send_byte(8'h03);
      send_byte(8'h00);
      send_byte(8'h03);
      send_byte(8'hAA);
      check("ovl_stop", stop_pulse, 1'b1);
      check("ovl_playing", playing, 1'b0);
      check("ovl_busy", busy, 1'b1);
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h02);
      tick(1);
      check("ovl_start", start_pulse, 1'b1);
      check("ovl_playing2", playing, 1'b1);

      // Reset after ARG byte: pending packet is lost, nothing counted
      send_byte(8'hAA);
      send_byte(8'h01);
      send_byte(8'h05);
      rst = 1'b0;
      tick(1);
      check("mid_rst_choose", choose, 4'd0);
      check("mid_rst_playing", playing, 1'b0);
      check("mid_rst_pulses", {start_pulse, stop_pulse}, 2'b00);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_err", err_cnt, 8'd0);
      rst = 1'b1;
      send_byte(8'h04);
      check("stale_chk_busy", busy, 1'b0);
      send_pkt(8'h01, 8'h04, 8'h05);
      check("post_rst_choose", choose, 4'd4);
      check("post_rst_err", err_cnt, 8'd0);

      // Timeout after CMD byte
      send_byte(8'hAA);
      send_byte(8'h01);
      tick(TIMEOUT_CYC - 1);
      check("to_busy_before", busy, 1'b1);
      check("to_err_before", err_cnt, 8'd0);
      tick(1);
      check("to_busy_after", busy, 1'b0);
      check("to_err_after", err_cnt, 8'd1);

      // Byte arriving exactly at expiry wins
      send_byte(8'hAA);
      tick(TIMEOUT_CYC - 1);
      send_byte(8'h02);
      check("edge_busy", busy, 1'b1);
      send_byte(8'h00);
      send_byte(8'h02);
      tick(1);
      check("edge_start", start_pulse, 1'b1);
      check("edge_err", err_cnt, 8'd1);

      // Saturation of the error counter
      for (int i = 0; i < 254; i++) send_pkt(8'h03, 8'h00, 8'hFF);
      check("sat_reach", err_cnt, 8'd255);
      send_pkt(8'h03, 8'h00, 8'hFF);
      send_pkt(8'h03, 8'h00, 8'hFF);
      check("sat_hold", err_cnt, 8'd255);
      check("sat_playing", playing, 1'b1);
      check("sat_choose", choose, 4'd4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
